// File: rtl/bsg_lane_permute_buffered.sv
// bsg_lane_permute_buffered
//   Permutes the lanes of an input word (pass, half-swap, rotate, reverse) and
//   captures the result in a two-entry FIFO. The input side is ready/valid and
//   the output side is valid/yumi.
//
// Ports
//   clk_i    : clock
//   reset_i  : synchronous active-high reset
//   data_i   : input word, lane k = data_i[k*width_p +: width_p]
//   op_i     : 0 pass, 1 half-swap, 2 rotate toward lower lanes, 3 reverse
//   amt_i    : rotate amount, only used when op_i = 2
//   v_i      : input valid
//   ready_o  : block can accept; transfer on v_i & ready_o
//   data_o   : permuted word at buffer head (meaningful only when v_o = 1)
//   v_o      : buffer head valid
//   yumi_i   : consumer takes head; ignored when the buffer is empty
module bsg_lane_permute_buffered #(
  parameter int unsigned width_p = 16,
  parameter int unsigned els_p   = 2,
  localparam int unsigned lg_els_lp = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [width_p*els_p-1:0]   data_i,
  input  logic [1:0]                 op_i,
  input  logic [lg_els_lp-1:0]       amt_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [width_p*els_p-1:0]   data_o,
  output logic                       v_o,
  input  logic                       yumi_i
);

  localparam int unsigned WordW = width_p * els_p;

  logic [WordW-1:0] perm;
  logic [WordW-1:0] mem_q [2];
  logic [WordW-1:0] mem_d [2];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       count_q, count_d;
  logic             enq, deq;

  // Output lane k takes input lane src; els_p is a power of two so the
  // modulo is a simple wrap.
  always_comb begin
    int unsigned src;
    perm = '0;
    src  = 0;
    for (int unsigned k = 0; k < els_p; k++) begin
      case (op_i)
        2'd0:    src = k;
        2'd1:    src = (k + els_p / 2) % els_p;
        2'd2:    src = (k + 32'(amt_i)) % els_p;
        default: src = els_p - 1 - k;
      endcase
      perm[k*width_p +: width_p] = data_i[src*width_p +: width_p];
    end
  end

  assign ready_o = (count_q != 2'd2) & ~reset_i;
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[rptr_q];

  assign enq = v_i & ready_o;
  // A yumi against an empty buffer is dropped so count cannot underflow.
  assign deq = yumi_i & v_o;

  always_comb begin
    mem_d = mem_q;
    if (enq) begin
      mem_d[wptr_q] = perm;
    end
  end

  always_comb begin
    wptr_d  = wptr_q ^ enq;
    rptr_d  = rptr_q ^ deq;
    count_d = count_q;
    if (enq && !deq) begin
      count_d = count_q + 2'd1;
    end else if (!enq && deq) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/bsg_lane_permute_buffered.md
Name: bsg_lane_permute_buffered

Overview:
- Parametrised, buffered successor to the fixed two-half swap. Generalises it to els_p lanes of width_p bits, with a per-transaction op: pass, half-swap, rotate or reverse.
- The permuted word is captured in a two-entry output buffer.
- Sits between a ready/valid producer and a valid/yumi consumer, e.g. the endian/lane-alignment stage ahead of a network link.

Parameters:
- width_p, 16, bits per lane; must be >= 1.
- els_p, 2, number of lanes; power of two, >= 2.
- lg_els_lp, $clog2(els_p), local; width of amt_i.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- data_i  in  width_p*els_p  input word; lane k = bits [k*width_p +: width_p].
- op_i  in  2  0=pass, 1=half-swap, 2=rotate, 3=reverse.
- amt_i  in  lg_els_lp  rotate amount; ignored unless op_i=2.
- v_i  in  1  input valid.
- ready_o  out  1  block can accept; an input transfer occurs when v_i & ready_o.
- data_o  out  width_p*els_p  permuted word at buffer head.
- v_o  out  1  buffer head valid.
- yumi_i  in  1  consumer takes head; legal only when v_o=1.

Behaviour:
- Clock and reset: single clock clk_i; reset_i synchronous, active-high.
- Permutation is combinational on data_i/op_i/amt_i at the accept edge, out lane k:
  - op 0: in lane k.
  - op 1: in lane (k + els_p/2) mod els_p. For els_p=2, width_p=16 this gives data_o = {data_i[15:0], data_i[31:16]}.
  - op 2: in lane (k + amt_i) mod els_p, i.e. rotate toward lower lanes; amt_i=0 is identical to pass.
  - op 3: in lane (els_p-1-k).
- Buffer:
  - Two entries, circular, with 1-bit read/write pointers and 2-bit count (0..2).
  - ready_o = (count != 2) & ~reset_i.
  - v_o = (count != 0).
  - data_o = entry at read pointer; X-free only when v_o=1, and held stable while v_o=1 and yumi_i=0.
- Latency: a word accepted at edge N appears on data_o/v_o after edge N (same-cycle bypass is not permitted). Order is strictly FIFO.
- Simultaneous events:
  - Enqueue plus yumi in the same cycle: count unchanged; both pointers advance.
  - When count=2, ready_o=0 even if yumi_i=1 that cycle; no enqueue-while-full.
  - Steady state with yumi every cycle sustains one word per cycle.
- Boundaries:
  - Pointers wrap 1→0.
  - yumi_i with v_o=0 is illegal; the bench flags it as an assertion error. RTL must not underflow count (yumi is ignored when empty).
- Reset:
  - While reset_i=1: ready_o=0, v_o=0, count=0, pointers=0.
  - Buffer contents are not reset.
  - Reset mid-operation discards all buffered words; first accept is possible on the cycle after reset_i falls.
- op_i/amt_i are sampled only on an accepting cycle; there is no sticky mode state.

Test Plan:
- Reset then idle: reset_i=1 for 3 cycles, release -> ready_o=1, v_o=0; no spurious output over 10 cycles.
- Legacy equivalence (width_p=16, els_p=2): op=1, data_i=32'hAAAA_5555, yumi held 1 -> one cycle later data_o=32'h5555_AAAA, v_o=1. Then op=0 with the same data -> 32'hAAAA_5555.
- Rotate/reverse (width_p=8, els_p=4): data_i=32'h4433_2211.
  - op=2, amt=1 -> 32'h1144_3322.
  - op=2, amt=3 -> 32'h3322_1144.
  - op=3 -> 32'h1122_3344.
- Back-pressure: yumi_i=0, v_i=1 with words A,B,C:
  - A and B accepted; ready_o=0 after the second accept; C is held by the producer.
  - Assert yumi_i for one cycle -> A leaves, ready_o=1, C enqueued next.
  - Output order is A,B,C with data_o stable while stalled.
- Full throughput: 100 random words with random op/amt, v_i=1 and yumi_i=1 continuously -> 100 outputs in 101 cycles, all matching the reference model.
- Reset mid-stream: count=2, assert reset_i for 1 cycle -> v_o=0 next cycle; the next accepted word is the first output, and the discarded words never appear.
